led_share_sched: RTL and testbench

Round-robin scheduler that shares one board LED among `N_REQ` requesters; each granted requester gets a burst of 1–15 blinks with fixed on/off phase lengths. It is the controller in front of the LED pin, replacing per-source free-running blinkers. It uses a single phase counter and one FSM. Arbitration is fair: the requester just served has lowest priority for the next grant.

---
 rtl/led_sched_pkg.sv | 17 +
 rtl/rr_pick.sv | 31 +++
 rtl/led_share_sched.sv | 149 ++++++++++++++
 tb/tb_led_share_sched.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_sched_pkg.sv
// Shared types and defaults for the LED sharing scheduler.
// Holds the burst FSM state encoding, blink-field width and default tick counts.
package led_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int BLINK_W       = 4;
    localparam int DEF_CNT_W     = 27;
    localparam int DEF_ON_TICKS  = 50_000_000;
    localparam int DEF_OFF_TICKS = 25_000_000;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin select: first set request at or after ptr, wrapping.
// Reusable by any scheduler sharing a single resource among N requesters.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  pick,
    output logic [IW-1:0] idx,
    output logic          valid
);

    int j;

    always_comb begin
        pick  = '0;
        idx   = '0;
        valid = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!valid && req[j]) begin
                valid   = 1'b1;
                pick[j] = 1'b1;
                idx     = IW'(j);
            end
        end
    end

endmodule

// File: rtl/led_share_sched.sv
// Shares one LED among N_REQ requesters; each grant plays a burst of blinks,
// then the pointer moves past the served requester so arbitration stays fair.
module led_share_sched
    import led_sched_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int ON_TICKS  = DEF_ON_TICKS,
    parameter int OFF_TICKS = DEF_OFF_TICKS
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [4*N_REQ-1:0]     blinks,
    output logic [N_REQ-1:0]       gnt,
    output logic                   led,
    output logic                   busy,
    output logic                   done,
    output state_t                 state_dbg
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BLINK_W-1:0]   rem_q, rem_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [N_REQ-1:0]     gnt_q, gnt_d;
    logic                 led_q, led_d;
    logic                 done_q, done_d;

    logic [N_REQ-1:0]     pick;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_valid;
    logic [BLINK_W-1:0]   fld;
    logic [IDX_W-1:0]     ptr_adv;
    logic                 still_req;

    rr_pick #(.N(N_REQ), .IW(IDX_W)) u_rr_pick (
        .req   (req),
        .ptr   (ptr_q),
        .pick  (pick),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        gnt_d     = gnt_q;
        led_d     = led_q;
        done_d    = 1'b0;
        fld       = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_idx == IDX_W'(i)) fld = blinks[BLINK_W*i +: BLINK_W];
        end
        ptr_adv   = IDX_W'((int'(idx_q) + 1) % N_REQ);
        still_req = |(req & gnt_q);

        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d = ST_ON;
                    gnt_d   = pick;
                    idx_d   = pick_idx;
                    rem_d   = (fld == '0) ? BLINK_W'(1) : fld;
                    cnt_d   = '0;
                    led_d   = 1'b1;
                end
            end
            ST_ON, ST_OFF: begin
                // Abort wins over phase completion: a dropped request never sees done.
                if (!still_req) begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                    led_d   = 1'b0;
                    cnt_d   = '0;
                    rem_d   = '0;
                    ptr_d   = ptr_adv;
                end else if (state_q == ST_ON) begin
                    if (cnt_q == CNT_W'(ON_TICKS - 1)) begin
                        cnt_d   = '0;
                        state_d = ST_OFF;
                        led_d   = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    if (cnt_q == CNT_W'(OFF_TICKS - 1)) begin
                        cnt_d = '0;
                        rem_d = rem_q - BLINK_W'(1);
                        if (rem_q == BLINK_W'(1)) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_ON;
                            led_d   = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                ptr_d   = ptr_adv;
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                led_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            ptr_q   <= '0;
            idx_q   <= '0;
            gnt_q   <= '0;
            led_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            gnt_q   <= gnt_d;
            led_q   <= led_d;
            done_q  <= done_d;
        end
    end

    assign gnt       = gnt_q;
    assign led       = led_q;
    assign done      = done_q;
    assign busy      = (state_q != ST_IDLE);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_led_share_sched.sv
// Bench for led_share_sched: directed burst scenarios plus a randomized run,
// all cycles checked against a burst-timeline reference model.
module tb_led_share_sched;
    import led_sched_pkg::*;

    localparam int N   = 4;
    localparam int ON  = 3;
    localparam int OFF = 2;
    localparam int P   = ON + OFF;

    logic          clk;
    logic          rst_n;
    logic [N-1:0]  req;
    logic [4*N-1:0] blinks;
    logic [N-1:0]  gnt;
    logic          led;
    logic          busy;
    logic          done;
    state_t        state_dbg;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: a burst is a timeline t = 0 .. n*P, t == n*P is the done cycle.
    bit   m_active;
    int   m_who;
    int   m_t;
    int   m_n;
    int   m_ptr;
    logic [1:0] exp_q[$];

    led_share_sched #(
        .N_REQ(N), .CNT_W(8), .ON_TICKS(ON), .OFF_TICKS(OFF)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .blinks    (blinks),
        .gnt       (gnt),
        .led       (led),
        .busy      (busy),
        .done      (done),
        .state_dbg (state_dbg)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests_run++;
        if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    function automatic int onehot_idx(input logic [N-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < N; i++) if (v[i]) r = i;
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 1'b0;
            m_t      = 0;
            m_n      = 0;
            m_who    = 0;
            m_ptr    = 0;
            exp_q.delete();
        end else if (m_active) begin
            if (m_t < m_n * P && !req[m_who]) begin
                m_active = 1'b0;
                m_ptr    = (m_who + 1) % N;
            end else if (m_t == m_n * P) begin
                m_active = 1'b0;
                m_ptr    = (m_who + 1) % N;
            end else begin
                m_t++;
                if (m_t == m_n * P) exp_q.push_back(2'(m_who));
            end
        end else if (req != '0) begin
            for (int k = N - 1; k >= 0; k--) begin
                if (req[(m_ptr + k) % N]) m_who = (m_ptr + k) % N;
            end
            m_active = 1'b1;
            m_t      = 0;
            m_n      = int'((blinks >> (4 * m_who)) & 16'hF);
            if (m_n == 0) m_n = 1;
        end
    end

    // Scoreboard: every cycle against the model, each done against the expected queue
    always @(negedge clk) begin
        if (rst_n) begin
            check("gnt",  32'(gnt),  m_active ? 32'(1 << m_who) : 32'd0);
            check("busy", 32'(busy), 32'(m_active));
            check("done", 32'(done), 32'(m_active && m_t == m_n * P));
            check("led",  32'(led),  32'(m_active && m_t < m_n * P && (m_t % P) < ON));
            if (done) begin
                if (exp_q.size() == 0) check("done_unexpected", 32'd1, 32'd0);
                else check("done_idx", 32'(onehot_idx(gnt)), 32'(exp_q.pop_front()));
            end
        end
    end

    // Driver tasks
    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n  = 1'b0;
        req    = '0;
        blinks = '0;
        #1;
        check("rst_led",  32'(led),  32'd0);
        check("rst_gnt",  32'(gnt),  32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic single_burst();
        logic [9:0]  pat;
        logic [11:0] dmask;
        do_reset();
        pat   = '0;
        dmask = '0;
        blinks = 16'h0020;
        req    = 4'b0010;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c == 0) check("s1_gnt", 32'(gnt), 32'b0010);
            if (c < 10) pat = {pat[8:0], led};
            if (done) dmask[c] = 1'b1;
            if (c == 10) req = '0;
            if (c == 11) check("s1_gnt_drop", 32'(gnt), 32'd0);
        end
        check("s1_led_pattern", 32'(pat), 32'b1110011100);
        check("s1_done_cycle", 32'(dmask), 32'h400);
    endtask

    task automatic round_robin();
        logic [7:0]   order;
        int           ng, ndone, idle_gap;
        logic [N-1:0] prev;
        do_reset();
        order = '0; ng = 0; ndone = 0; idle_gap = 0; prev = '0;
        blinks = 16'h1111;
        req    = 4'b1011;
        for (int c = 0; c < 100 && ndone < 4; c++) begin
            @(negedge clk);
            if (gnt != '0 && prev == '0 && ng < 4) begin
                order = {order[5:0], 2'(onehot_idx(gnt))};
                ng++;
            end
            if (gnt == '0 && ng > 0) idle_gap++;
            if (done) ndone++;
            prev = gnt;
        end
        req = '0;
        check("rr_order", 32'(order), 32'b00_01_11_00);
        check("rr_done_count", 32'(ndone), 32'd4);
        check("rr_idle_cycles", 32'(idle_gap), 32'd3);
    endtask

    task automatic zero_count();
        int nled, ndone, ngnt;
        do_reset();
        nled = 0; ndone = 0; ngnt = 0;
        blinks = 16'h0000;
        req    = 4'b0001;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (led) nled++;
            if (gnt != '0) ngnt++;
            if (done) begin
                ndone++;
                req = '0;
            end
        end
        check("z_led_high", 32'(nled), 32'd3);
        check("z_done", 32'(ndone), 32'd1);
        check("z_gnt_cycles", 32'(ngnt), 32'd6);
    endtask

    task automatic abort_case();
        int ndone;
        do_reset();
        ndone  = 0;
        blinks = 16'h0300;
        req    = 4'b0100;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (done) ndone++;
            if (c == 5) begin
                check("ab_led_on2", 32'(led), 32'd1);
                req = '0;
            end
        end
        @(negedge clk);
        if (done) ndone++;
        check("ab_led", 32'(led), 32'd0);
        check("ab_gnt", 32'(gnt), 32'd0);
        check("ab_no_done", 32'(ndone), 32'd0);
        req = 4'hF;
        @(negedge clk);
        check("ab_next_gnt", 32'(gnt), 32'b1000);
        for (int c = 0; c < 20 && !done; c++) @(negedge clk);
        check("ab_next_done", 32'(done), 32'd1);
        req = '0;
    endtask

    task automatic async_reset_case();
        do_reset();
        blinks = 16'h0001;
        req    = 4'b0001;
        repeat (4) @(posedge clk);
        #2;
        check("ar_pre_state", 32'(state_dbg), 32'(ST_OFF));
        rst_n = 1'b0;
        #1;
        check("ar_led",  32'(led),  32'd0);
        check("ar_gnt",  32'(gnt),  32'd0);
        check("ar_busy", 32'(busy), 32'd0);
        check("ar_done", 32'(done), 32'd0);
        @(negedge clk);
        req    = 4'hF;
        blinks = 16'h0000;
        rst_n  = 1'b1;
        @(negedge clk);
        check("ar_regrant", 32'(gnt), 32'b0001);
        req = '0;
        repeat (3) @(negedge clk);
    endtask

    task automatic random_run(input int cycles);
        logic [N-1:0] r;
        do_reset();
        for (int cyc = 0; cyc < cycles; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                blinks[4*i +: 4] = 4'($urandom_range(0, 3));
                if (m_active && i == m_who) r[i] = ($urandom_range(0, 39) != 0);
                else r[i] = 1'($urandom_range(0, 1));
            end
            req = r;
        end
        req = '0;
        repeat (20) @(negedge clk);
        check("rand_queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        rst_n  = 1'b0;
        req    = '0;
        blinks = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        single_burst();
        round_robin();
        zero_count();
        abort_case();
        async_reset_case();
        random_run(3000);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
